// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: one packed payload with valid/ready handshake,
// an optional skid entry for a registered ready, synchronous flush and a stall counter.
module pipe_stage_reg #(
    parameter int DATA_W        = 80,
    parameter int SKID          = 1,
    parameter int ZERO_ON_FLUSH = 0,
    parameter int CNT_W         = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_flush,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;
    logic load_main;

    // With a skid entry, ready comes straight from a flop; otherwise it looks through to i_ready.
    if (SKID != 0) begin : g_ready_skid
        assign ready = ~skid_valid_q;
    end else begin : g_ready_comb
        assign ready = i_ready | ~valid_q;
    end

    assign in_fire   = i_valid & ready;
    assign out_fire  = valid_q & i_ready;
    assign load_main = out_fire | ~valid_q;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (i_flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            if (ZERO_ON_FLUSH != 0) begin
                data_d      = '0;
                skid_data_d = '0;
            end
        end else if (SKID != 0) begin
            if (load_main) begin
                // The skid entry is older than anything on the input, so it drains first.
                if (skid_valid_q) begin
                    valid_d      = 1'b1;
                    data_d       = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    valid_d = 1'b1;
                    data_d  = i_data;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = i_data;
            end
        end else begin
            if (in_fire) begin
                valid_d = 1'b1;
                data_d  = i_data;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !i_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations (skid, skid+zero-on-flush+4-bit counter,
// no skid), directed vectors plus randomized traffic against a FIFO-occupancy model.
module tb_pipe_stage_reg;

    logic clk;
    logic rst;

    logic        v_in  [3];
    logic [79:0] d_in  [3];
    logic        r_in  [3];
    logic        f_in  [3];

    logic        o_valid [3];
    logic        o_ready [3];
    logic [79:0] o_data  [3];
    logic [15:0] o_stall [3];

    logic [79:0] da;
    logic [15:0] dz, dc;
    logic [15:0] sa, sc;
    logic [3:0]  sz;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[0]), .ready(o_ready[0]), .i_data(d_in[0]),
        .i_flush(f_in[0]), .valid(o_valid[0]), .data(da), .i_ready(r_in[0]), .stall_cnt(sa)
    );

    pipe_stage_reg #(.DATA_W(16), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(4)) u_z (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[1]), .ready(o_ready[1]), .i_data(d_in[1][15:0]),
        .i_flush(f_in[1]), .valid(o_valid[1]), .data(dz), .i_ready(r_in[1]), .stall_cnt(sz)
    );

    pipe_stage_reg #(.DATA_W(16), .SKID(0), .ZERO_ON_FLUSH(0), .CNT_W(16)) u_c (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[2]), .ready(o_ready[2]), .i_data(d_in[2][15:0]),
        .i_flush(f_in[2]), .valid(o_valid[2]), .data(dc), .i_ready(r_in[2]), .stall_cnt(sc)
    );

    assign o_data[0]  = da;
    assign o_data[1]  = {64'b0, dz};
    assign o_data[2]  = {64'b0, dc};
    assign o_stall[0] = sa;
    assign o_stall[1] = {12'b0, sz};
    assign o_stall[2] = sc;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            v_in[k] = 1'b0;
            d_in[k] = '0;
            r_in[k] = 1'b1;
            f_in[k] = 1'b0;
        end
    endtask

    task automatic step(input int k, input logic v, input logic [79:0] d,
                        input logic r, input logic f);
        @(negedge clk);
        v_in[k] = v;
        d_in[k] = d;
        r_in[k] = r;
        f_in[k] = f;
        @(posedge clk);
        #1;
    endtask

    // Reference: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [79:0] mslot [3][2];
    int          mcnt  [3];
    int          mstall[3];
    bit          mzero [3];
    int          cap   [3] = '{2, 2, 1};
    int          smax  [3] = '{65535, 15, 65535};
    bit          zof   [3] = '{1'b0, 1'b1, 1'b0};
    logic [79:0] wmask [3];

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        for (int k = 0; k < 3; k++) begin
            mcnt[k]     = 0;
            mstall[k]   = 0;
            mzero[k]    = 1'b1;
            mslot[k][0] = '0;
            mslot[k][1] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 80'(o_valid[k]), 80'(0));
            chk($sformatf("rst_data[%0d]", k),  o_data[k], 80'(0));
            chk($sformatf("rst_stall[%0d]", k), 80'(o_stall[k]), 80'(0));
            chk($sformatf("rst_ready[%0d]", k), 80'(o_ready[k]), 80'(1));
        end
    endtask

    typedef struct {
        logic        v;
        logic [79:0] d;
        logic        r;
        logic        f;
        logic        ev;
        logic [79:0] ed;
        logic        er;
        logic [15:0] es;
    } vec_t;

    function automatic vec_t mk(logic v, logic [79:0] d, logic r, logic f,
                                logic ev, logic [79:0] ed, logic er, logic [15:0] es);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.f = f;
        t.ev = ev; t.ed = ed; t.er = er; t.es = es;
        return t;
    endfunction

    vec_t tbl[18];

    logic [95:0] rnd;
    logic        ex_in  [3];
    logic        ex_out [3];

    initial begin
        wmask[0] = '1;
        wmask[1] = {64'b0, 16'hFFFF};
        wmask[2] = {64'b0, 16'hFFFF};

        // streaming
        tbl[0]  = mk(1'b1, 80'h1, 1'b1, 1'b0, 1'b1, 80'h1, 1'b1, 16'd0);
        tbl[1]  = mk(1'b1, 80'h2, 1'b1, 1'b0, 1'b1, 80'h2, 1'b1, 16'd0);
        tbl[2]  = mk(1'b1, 80'h3, 1'b1, 1'b0, 1'b1, 80'h3, 1'b1, 16'd0);
        tbl[3]  = mk(1'b1, 80'h4, 1'b1, 1'b0, 1'b1, 80'h4, 1'b1, 16'd0);
        tbl[4]  = mk(1'b0, 80'h0, 1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 16'd0);
        // backpressure: A in main, B to skid, C refused until drained
        tbl[5]  = mk(1'b1, 80'hA, 1'b1, 1'b0, 1'b1, 80'hA, 1'b1, 16'd0);
        tbl[6]  = mk(1'b1, 80'hB, 1'b0, 1'b0, 1'b1, 80'hA, 1'b0, 16'd1);
        tbl[7]  = mk(1'b1, 80'hC, 1'b0, 1'b0, 1'b1, 80'hA, 1'b0, 16'd2);
        tbl[8]  = mk(1'b1, 80'hC, 1'b0, 1'b0, 1'b1, 80'hA, 1'b0, 16'd3);
        tbl[9]  = mk(1'b1, 80'hC, 1'b1, 1'b0, 1'b1, 80'hB, 1'b1, 16'd3);
        tbl[10] = mk(1'b1, 80'hC, 1'b1, 1'b0, 1'b1, 80'hC, 1'b1, 16'd3);
        tbl[11] = mk(1'b0, 80'h0, 1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 16'd3);
        // flush with both entries full, then flush discarding an accepted input
        tbl[12] = mk(1'b1, 80'h5, 1'b1, 1'b0, 1'b1, 80'h5, 1'b1, 16'd3);
        tbl[13] = mk(1'b1, 80'h6, 1'b0, 1'b0, 1'b1, 80'h5, 1'b0, 16'd4);
        tbl[14] = mk(1'b1, 80'h7, 1'b0, 1'b1, 1'b0, 80'h0, 1'b1, 16'd5);
        tbl[15] = mk(1'b0, 80'h0, 1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 16'd5);
        tbl[16] = mk(1'b1, 80'h8, 1'b1, 1'b1, 1'b0, 80'h0, 1'b1, 16'd5);
        tbl[17] = mk(1'b0, 80'h0, 1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 16'd5);

        do_reset();

        for (int t = 0; t < 18; t++) begin
            step(0, tbl[t].v, tbl[t].d, tbl[t].r, tbl[t].f);
            chk($sformatf("tbl%0d_valid", t), 80'(o_valid[0]), 80'(tbl[t].ev));
            if (tbl[t].ev) chk($sformatf("tbl%0d_data", t), o_data[0], tbl[t].ed);
            chk($sformatf("tbl%0d_ready", t), 80'(o_ready[0]), 80'(tbl[t].er));
            chk($sformatf("tbl%0d_stall", t), 80'(o_stall[0]), 80'(tbl[t].es));
        end

        // no-skid configuration: ready follows i_ready within the cycle
        step(2, 1'b1, 80'h11, 1'b1, 1'b0);
        chk("c_load_valid", 80'(o_valid[2]), 80'(1));
        chk("c_load_data", o_data[2], 80'h11);
        @(negedge clk);
        v_in[2] = 1'b1; d_in[2] = 80'h22; r_in[2] = 1'b0;
        #1 chk("c_ready_low", 80'(o_ready[2]), 80'(0));
        @(posedge clk); #1;
        chk("c_hold_data", o_data[2], 80'h11);
        chk("c_hold_stall", 80'(o_stall[2]), 80'(1));
        @(negedge clk);
        d_in[2] = 80'h33; r_in[2] = 1'b1;
        #1 chk("c_ready_high", 80'(o_ready[2]), 80'(1));
        @(posedge clk); #1;
        chk("c_repl1_data", o_data[2], 80'h33);
        @(negedge clk);
        d_in[2] = 80'h44;
        #1 chk("c_ready_high2", 80'(o_ready[2]), 80'(1));
        @(posedge clk); #1;
        chk("c_repl2_data", o_data[2], 80'h44);
        step(2, 1'b0, 80'h0, 1'b1, 1'b0);
        chk("c_drain_valid", 80'(o_valid[2]), 80'(0));

        // zero-on-flush, saturation, async reset
        step(1, 1'b1, 80'h5, 1'b1, 1'b0);
        step(1, 1'b1, 80'h6, 1'b0, 1'b0);
        chk("z_skid_ready", 80'(o_ready[1]), 80'(0));
        step(1, 1'b1, 80'h7, 1'b0, 1'b1);
        chk("z_flush_valid", 80'(o_valid[1]), 80'(0));
        chk("z_flush_data", o_data[1], 80'(0));
        chk("z_flush_ready", 80'(o_ready[1]), 80'(1));
        chk("z_flush_stall", 80'(o_stall[1]), 80'(2));
        step(1, 1'b0, 80'h0, 1'b1, 1'b0);
        chk("z_after_flush_valid", 80'(o_valid[1]), 80'(0));
        chk("z_after_flush_data", o_data[1], 80'(0));
        step(1, 1'b1, 80'h9, 1'b1, 1'b0);
        repeat (20) step(1, 1'b0, 80'h0, 1'b0, 1'b0);
        chk("z_sat_stall", 80'(o_stall[1]), 80'(15));
        chk("z_sat_data", o_data[1], 80'h9);
        repeat (3) step(1, 1'b0, 80'h0, 1'b0, 1'b0);
        chk("z_sat_hold", 80'(o_stall[1]), 80'(15));
        #2 rst = 1'b1;
        #1;
        chk("z_arst_valid", 80'(o_valid[1]), 80'(0));
        chk("z_arst_data", o_data[1], 80'(0));
        chk("z_arst_stall", 80'(o_stall[1]), 80'(0));
        @(negedge clk);
        rst = 1'b0;
        idle_all();
        #1 chk("z_arst_ready", 80'(o_ready[1]), 80'(1));
        step(1, 1'b0, 80'h0, 1'b1, 1'b0);
        chk("z_post_rst_empty", 80'(o_valid[1]), 80'(0));
        step(1, 1'b1, 80'h3C, 1'b1, 1'b0);
        chk("z_post_rst_valid", 80'(o_valid[1]), 80'(1));
        chk("z_post_rst_data", o_data[1], 80'h3C);
        step(1, 1'b0, 80'h0, 1'b1, 1'b0);
        chk("z_post_rst_drain", 80'(o_valid[1]), 80'(0));

        // randomized traffic on all three against the FIFO model
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                rnd     = {$urandom(), $urandom(), $urandom()};
                v_in[k] = ($urandom_range(0, 99) < 70);
                d_in[k] = rnd[79:0];
                r_in[k] = ($urandom_range(0, 99) < 60);
                f_in[k] = ($urandom_range(0, 99) < 5);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                logic exp_rdy;
                exp_rdy = (mcnt[k] < cap[k]) || (cap[k] == 1 && r_in[k]);
                chk($sformatf("rnd_ready[%0d]", k), 80'(o_ready[k]), 80'(exp_rdy));
                ex_in[k]  = v_in[k] && exp_rdy;
                ex_out[k] = (mcnt[k] > 0) && r_in[k];
            end
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (mcnt[k] > 0 && !r_in[k] && mstall[k] < smax[k]) mstall[k]++;
                if (f_in[k]) begin
                    mcnt[k] = 0;
                    if (zof[k]) mzero[k] = 1'b1;
                end else begin
                    if (ex_out[k]) begin
                        mslot[k][0] = mslot[k][1];
                        mcnt[k]--;
                    end
                    if (ex_in[k]) begin
                        mslot[k][mcnt[k]] = d_in[k] & wmask[k];
                        mcnt[k]++;
                        mzero[k] = 1'b0;
                    end
                end
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rnd_valid[%0d]", k), 80'(o_valid[k]), 80'(mcnt[k] > 0));
                if (mcnt[k] > 0)
                    chk($sformatf("rnd_data[%0d]", k), o_data[k], mslot[k][0]);
                else if (mzero[k])
                    chk($sformatf("rnd_zero[%0d]", k), o_data[k], 80'(0));
                chk($sformatf("rnd_stall[%0d]", k), 80'(o_stall[k]), 80'(mstall[k]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed-field, free-running stage registers between pipeline stages. It carries one packed payload of DATA_W bits with a valid/ready handshake, and has an optional skid entry so the upstream ready is fully registered. It also provides a synchronous flush for branch/exception squash and a saturating stall counter for performance monitoring. It is instantiated between EX and MEM, and also between ID/EX and MEM/WB, with the payload packed by the surrounding stage.

Parameters:
DATA_W, 80, payload width in bits (default packs rs_2 32 + rd_num 5 + alu_out 32 + opcode 7 + func_3 3 + op_type 1).
SKID, 1, 1 = two-entry skid buffer with registered ready; 0 = single entry with combinational ready.
ZERO_ON_FLUSH, 0, 1 = payload registers are cleared to 0 on flush; 0 = payload holds its value and only the valid bits clear.
CNT_W, 16, width of the stall counter.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_valid  input  1  upstream presents a payload.
ready  output  1  stage can accept a payload this cycle.
i_data  input  DATA_W  upstream payload.
i_flush  input  1  synchronous squash of all held entries.
valid  output  1  output payload is valid.
data  output  DATA_W  output payload.
i_ready  input  1  downstream accepts the payload this cycle.
stall_cnt  output  CNT_W  count of cycles with valid=1 and i_ready=0.

Behaviour:
- Reset (async, i_rst=1): valid=0, data=0, skid valid=0, skid data=0, stall_cnt=0. Ready is 1 once the stage leaves reset.
- Handshake terms: in_fire = i_valid & ready; out_fire = valid & i_ready. A payload is transferred only on a fire; no drops and no duplicates.
- Latency: 1 cycle from in_fire to valid=1 with an empty stage. Throughput is 1 payload/cycle while i_ready=1.
- SKID=1 mode:
  - ready = ~skid_valid, taken directly from a flop with no combinational path from i_ready.
  - Main register load (when out_fire or valid=0): takes the skid entry if skid_valid=1 and clears the skid; otherwise takes i_data if in_fire; otherwise valid goes to 0.
  - in_fire while valid=1 and i_ready=0: payload is captured into the skid entry, so ready=0 on the next cycle.
  - With both entries full and i_ready=0, the stage holds everything and ready stays 0.
  - Output order is strictly FIFO: main, then skid, then new input.
- SKID=0 mode:
  - ready = i_ready | ~valid (combinational).
  - On in_fire the main register loads i_data; on out_fire without in_fire, valid clears.
- Flush (i_flush=1 at a rising edge):
  - Next state is valid=0 and skid_valid=0. Flush has priority over any simultaneous in_fire or out_fire, and the input accepted in that cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed downstream; this is the downstream's responsibility.
  - ZERO_ON_FLUSH=1 clears data and skid data to 0.
- Hold: while valid=1 and i_ready=0, data is stable and unchanged.
- stall_cnt: increments by 1 on each rising edge where valid=1 and i_ready=0, including the cycle where i_flush is asserted. It saturates at 2^CNT_W-1 with no wrap. It is cleared only by i_rst; flush does not affect it.
- Reset mid-operation: all entries are lost immediately, and no payload emerges after i_rst deasserts until a new in_fire.
- data when valid=0: no guarantee, except that it equals 0 after reset and after a flush with ZERO_ON_FLUSH=1.

Test Plan:
- Streaming (SKID=1): i_ready=1; drive i_valid=1 with data 1,2,3,4 on consecutive cycles -> valid=1 with data 1,2,3,4 one cycle later each; ready stays 1; stall_cnt=0.
- Backpressure: send 0xA, 0xB, 0xC with i_ready=0 from the cycle 0xA appears -> data holds 0xA, 0xB goes to skid, ready=0, 0xC is not accepted. After 3 stalled cycles stall_cnt=3. Release i_ready -> outputs 0xA, 0xB, 0xC in order.
- Flush: main=0x5, skid=0x6, i_flush=1 with i_valid=1 and data 0x7 -> next cycle valid=0, ready=1, and 0x7 never appears. With ZERO_ON_FLUSH=1, data=0.
- SKID=0: i_ready=0 with valid=1 -> ready=0 in the same cycle; i_ready=1 with i_valid=1 -> ready=1 combinationally and data is replaced every cycle.
- Saturation: CNT_W=4, hold the stall for 20 cycles -> stall_cnt=15 and stays there.
- Async reset: assert i_rst mid-stall between clock edges -> valid=0, data=0, stall_cnt=0 immediately without a clock edge; deassert -> ready=1 and the first output is the next accepted payload.
